data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// CPU/DMA arbiter for a single-ported data memory: per-cycle CPU priority with
// DMA anti-starvation, locked DMA bursts, and 1-cycle read-data return routing.
module data_mem_arbiter #(
   parameter int DATA_WIDTH    = 20,
   parameter int ADDRESS_WIDTH = 20,
   parameter int STARVE_LIMIT  = 4,
   parameter int MAX_BURST     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic                     cpu_be,
   input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0]    cpu_wdata,
   output logic                     cpu_gnt,
   output logic                     cpu_stall,
   output logic                     cpu_rvalid,
   output logic [DATA_WIDTH-1:0]    cpu_rdata,
   input  logic                     dma_req,
   input  logic                     dma_we,
   input  logic                     dma_be,
   input  logic                     dma_lock,
   input  logic [ADDRESS_WIDTH-1:0] dma_addr,
   input  logic [DATA_WIDTH-1:0]    dma_wdata,
   output logic                     dma_gnt,
   output logic                     dma_rvalid,
   output logic [DATA_WIDTH-1:0]    dma_rdata,
   output logic                     mem_we,
   output logic                     mem_re,
   output logic                     mem_be,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [BW-1:0] BEAT_LAST  = BW'(MAX_BURST - 1);

   typedef enum logic       {ARB, BURST} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

   state_t          state;
   owner_t          owner;
   logic [SW-1:0]   starve_cnt;
   logic [BW-1:0]   beat_cnt;
   logic            suppress;
   logic            burst_exit;

   // Grants are gated by rst so every output is forced low while in reset.
   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (rst) begin
         if (state == BURST)
            dma_gnt = dma_req;
         else if (dma_req && (!cpu_req || (!suppress && starve_cnt == STARVE_MAX)))
            dma_gnt = 1'b1;
         else
            cpu_gnt = cpu_req;
      end
   end

   assign cpu_stall  = rst & cpu_req & ~cpu_gnt;
   assign burst_exit = (state == BURST) &&
                       (!dma_lock || !dma_req || (beat_cnt == BEAT_LAST));

   always_comb begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_be    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_re    = ~cpu_we;
         mem_be    = cpu_be;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (dma_gnt) begin
         mem_we    = dma_we;
         mem_re    = ~dma_we;
         mem_be    = dma_be;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end
   end

   assign cpu_rvalid = (owner == OWN_CPU);
   assign dma_rvalid = (owner == OWN_DMA);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
   assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ARB;
         owner      <= OWN_NONE;
         starve_cnt <= '0;
         beat_cnt   <= '0;
         suppress   <= 1'b0;
      end else begin
         suppress <= 1'b0;
         if (dma_gnt)
            starve_cnt <= '0;
         else if (dma_req && starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + 1'b1;

         if (cpu_gnt && !cpu_we)      owner <= OWN_CPU;
         else if (dma_gnt && !dma_we) owner <= OWN_DMA;
         else                         owner <= OWN_NONE;

         case (state)
            ARB: begin
               // The ARB grant that opens a burst counts as its first beat.
               if (dma_gnt && dma_lock && !suppress) begin
                  state    <= BURST;
                  beat_cnt <= BW'(1);
               end
            end
            BURST: begin
               if (dma_gnt) beat_cnt <= beat_cnt + 1'b1;
               if (burst_exit) begin
                  state    <= ARB;
                  beat_cnt <= '0;
                  suppress <= 1'b1;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a cycle table for arbitration, starvation
// and bursts, plus hand sequences for write, reset-in-burst and restart.
module tb_data_mem_arbiter;

   localparam int DW = 20;
   localparam int AW = 20;
   localparam logic [AW-1:0] CPU_A = 20'h00300;
   localparam logic [AW-1:0] DMA_A = 20'h00010;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we, cpu_be;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt, cpu_stall, cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          dma_req, dma_we, dma_be, dma_lock;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata;
   logic          dma_gnt, dma_rvalid;
   logic [DW-1:0] dma_rdata;
   logic          mem_we, mem_re, mem_be;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARVE_LIMIT(4), .MAX_BURST(8)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_lock(dma_lock),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
      .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_we(mem_we), .mem_re(mem_re), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic cr, cw, dr, dw, dl;
      logic [DW-1:0] rd;
      logic cg, dg, cs, crv, drv, mwe, mre;
      int   sc;
      logic sup;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic cr, logic cw, logic dr, logic dw, logic dl,
                               logic [DW-1:0] rd, logic cg, logic dg, logic cs,
                               logic crv, logic drv, logic mwe, logic mre,
                               int sc, logic sup);
      vec_t v;
      v.cr = cr; v.cw = cw; v.dr = dr; v.dw = dw; v.dl = dl; v.rd = rd;
      v.cg = cg; v.dg = dg; v.cs = cs; v.crv = crv; v.drv = drv;
      v.mwe = mwe; v.mre = mre; v.sc = sc; v.sup = sup;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_addr = CPU_A; cpu_wdata = 20'h0C0C0;
      dma_req = 0; dma_we = 0; dma_be = 0; dma_lock = 0; dma_addr = DMA_A;
      dma_wdata = 20'h0D0D0; mem_rdata = '0;
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, " cpu_gnt"},    cpu_gnt, 0);
      chk({nm, " dma_gnt"},    dma_gnt, 0);
      chk({nm, " cpu_stall"},  cpu_stall, 0);
      chk({nm, " cpu_rvalid"}, cpu_rvalid, 0);
      chk({nm, " dma_rvalid"}, dma_rvalid, 0);
      chk({nm, " cpu_rdata"},  cpu_rdata, 0);
      chk({nm, " dma_rdata"},  dma_rdata, 0);
      chk({nm, " mem_we"},     mem_we, 0);
      chk({nm, " mem_re"},     mem_re, 0);
      chk({nm, " mem_be"},     mem_be, 0);
      chk({nm, " mem_addr"},   mem_addr, 0);
      chk({nm, " mem_wdata"},  mem_wdata, 0);
   endtask

   initial begin
      //                 cr cw dr dw dl rd         cg dg cs crv drv mwe mre sc sup
      // Starvation: CPU x4 then DMA, reads on both sides
      tbl.push_back(mk(1,0,1,0,0, 20'h00100, 1,0,0,0,0, 0,1, 0,0));
      tbl.push_back(mk(1,0,1,0,0, 20'h00101, 1,0,0,1,0, 0,1, 1,0));
      tbl.push_back(mk(1,0,1,0,0, 20'h00102, 1,0,0,1,0, 0,1, 2,0));
      tbl.push_back(mk(1,0,1,0,0, 20'h00103, 1,0,0,1,0, 0,1, 3,0));
      tbl.push_back(mk(1,0,1,0,0, 20'h00104, 0,1,1,1,0, 0,1, 4,0));
      tbl.push_back(mk(1,0,1,0,0, 20'h00105, 1,0,0,0,1, 0,1, 0,0));
      tbl.push_back(mk(1,0,1,0,0, 20'h00106, 1,0,0,1,0, 0,1, 1,0));
      tbl.push_back(mk(1,0,1,0,0, 20'h00107, 1,0,0,1,0, 0,1, 2,0));
      tbl.push_back(mk(1,0,1,0,0, 20'h00108, 1,0,0,1,0, 0,1, 3,0));
      tbl.push_back(mk(1,0,1,0,0, 20'h00109, 0,1,1,1,0, 0,1, 4,0));
      tbl.push_back(mk(0,0,0,0,0, 20'h0010A, 0,0,0,0,1, 0,0, 0,0));
      // Lone DMA read, data returned next cycle
      tbl.push_back(mk(0,0,1,0,0, 20'h00000, 0,1,0,0,0, 0,1, 0,0));
      tbl.push_back(mk(0,0,0,0,0, 20'h0ABCD, 0,0,0,0,1, 0,0, 0,0));
      // Locked burst against a busy CPU: 4 CPU, 8 DMA beats, 1 suppressed CPU win
      tbl.push_back(mk(1,0,1,0,1, 20'h00200, 1,0,0,0,0, 0,1, 0,0));
      tbl.push_back(mk(1,0,1,0,1, 20'h00201, 1,0,0,1,0, 0,1, 1,0));
      tbl.push_back(mk(1,0,1,0,1, 20'h00202, 1,0,0,1,0, 0,1, 2,0));
      tbl.push_back(mk(1,0,1,0,1, 20'h00203, 1,0,0,1,0, 0,1, 3,0));
      tbl.push_back(mk(1,0,1,0,1, 20'h00204, 0,1,1,1,0, 0,1, 4,0));
      for (int k = 0; k < 7; k++)
         tbl.push_back(mk(1,0,1,0,1, 20'h00205 + 20'(k), 0,1,1,0,1, 0,1, 0,0));
      tbl.push_back(mk(1,0,1,0,1, 20'h0020C, 1,0,0,0,1, 0,1, 0,1));
      tbl.push_back(mk(1,0,1,0,1, 20'h0020D, 1,0,0,1,0, 0,1, 1,0));
      tbl.push_back(mk(0,0,0,0,0, 20'h0020E, 0,0,0,1,0, 0,0, 2,0));
      // Burst cut short by dma_lock=0 on beat 3; suppress then blocks re-entry
      tbl.push_back(mk(0,0,1,1,1, 20'h00000, 0,1,0,0,0, 1,0, 2,0));
      tbl.push_back(mk(0,0,1,1,1, 20'h00000, 0,1,0,0,0, 1,0, 0,0));
      tbl.push_back(mk(0,0,1,1,0, 20'h00000, 0,1,0,0,0, 1,0, 0,0));
      tbl.push_back(mk(0,0,1,1,1, 20'h00000, 0,1,0,0,0, 1,0, 0,1));
      tbl.push_back(mk(1,0,1,1,0, 20'h00000, 1,0,0,0,0, 0,1, 0,0));
      tbl.push_back(mk(0,0,0,0,0, 20'h00333, 0,0,0,1,0, 0,0, 1,0));

      idle_inputs();
      rst = 1'b0;
      #2;
      chk_quiet("reset");
      chk("reset starve_cnt", 32'(dut.starve_cnt), 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         vec_t v;
         string p;
         v = tbl[i];
         p = $sformatf("row%0d", i);
         @(negedge clk);
         cpu_req = v.cr; cpu_we = v.cw; cpu_be = 1'b1;
         dma_req = v.dr; dma_we = v.dw; dma_lock = v.dl; dma_be = 1'b0;
         mem_rdata = v.rd;
         #2;
         chk({p, " cpu_gnt"},    cpu_gnt, v.cg);
         chk({p, " dma_gnt"},    dma_gnt, v.dg);
         chk({p, " cpu_stall"},  cpu_stall, v.cs);
         chk({p, " cpu_rvalid"}, cpu_rvalid, v.crv);
         chk({p, " dma_rvalid"}, dma_rvalid, v.drv);
         chk({p, " cpu_rdata"},  cpu_rdata, v.crv ? v.rd : '0);
         chk({p, " dma_rdata"},  dma_rdata, v.drv ? v.rd : '0);
         chk({p, " mem_we"},     mem_we, v.mwe);
         chk({p, " mem_re"},     mem_re, v.mre);
         chk({p, " mem_be"},     mem_be, v.cg);
         chk({p, " mem_addr"},   mem_addr, v.cg ? CPU_A : (v.dg ? DMA_A : '0));
         chk({p, " starve_cnt"}, 32'(dut.starve_cnt), v.sc);
         chk({p, " suppress"},   dut.suppress, v.sup);
      end

      // CPU byte write: full mem_* passthrough, no read return afterwards
      @(negedge clk);
      idle_inputs();
      cpu_req = 1; cpu_we = 1; cpu_be = 1; cpu_addr = 20'h00020; cpu_wdata = 20'h12345;
      #2;
      chk("wr cpu_gnt",   cpu_gnt, 1);
      chk("wr mem_we",    mem_we, 1);
      chk("wr mem_re",    mem_re, 0);
      chk("wr mem_be",    mem_be, 1);
      chk("wr mem_addr",  mem_addr, 20'h00020);
      chk("wr mem_wdata", mem_wdata, 20'h12345);
      @(negedge clk);
      idle_inputs();
      mem_rdata = 20'h77777;
      #2;
      chk_quiet("wr after");

      // Reset while a locked DMA read burst is in flight
      @(negedge clk);
      dma_req = 1; dma_lock = 1; dma_we = 0;
      #2;
      chk("rb beat1 dma_gnt", dma_gnt, 1);
      @(negedge clk);
      cpu_req = 1; mem_rdata = 20'h55555;
      #2;
      chk("rb beat2 dma_gnt",    dma_gnt, 1);
      chk("rb beat2 cpu_stall",  cpu_stall, 1);
      chk("rb beat2 dma_rvalid", dma_rvalid, 1);
      chk("rb beat2 dma_rdata",  dma_rdata, 20'h55555);
      rst = 1'b0;
      #1;
      chk_quiet("rb in reset");
      @(negedge clk);
      idle_inputs();
      mem_rdata = 20'h55555;
      rst = 1'b1;
      #2;
      chk_quiet("rb released");
      @(negedge clk);
      #2;
      chk_quiet("rb idle");
      chk("rb idle state", 32'(dut.state), 0);
      @(negedge clk);
      cpu_req = 1; cpu_we = 0;
      #2;
      chk("rb restart cpu_gnt", cpu_gnt, 1);
      chk("rb restart mem_re",  mem_re, 1);
      @(negedge clk);
      idle_inputs();
      mem_rdata = 20'h0BEEF;
      #2;
      chk("rb restart cpu_rvalid", cpu_rvalid, 1);
      chk("rb restart cpu_rdata",  cpu_rdata, 20'h0BEEF);
      chk("rb restart dma_rvalid", dma_rvalid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
